// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// imm_pkg : shared types and constants for the immediate-generation stage
// Revision: 1.0
// ============================================================================
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_Z     = 3'b101,
    IMM_SHAMT = 3'b110,
    IMM_NONE  = 3'b111
  } imm_src_e;

  localparam int XLEN_RV32 = 32;
  localparam int XLEN_RV64 = 64;
  localparam int INST_W    = 32;

endpackage
`default_nettype wire

// File: rtl/imm_gen_stage_if.sv
`default_nettype none
// ============================================================================
// imm_gen_stage_if : upstream/downstream handshake bundle for imm_gen_stage
// Revision: 1.0
// ============================================================================
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_imm_src;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // master drives the stage (decode side + downstream ready), slave is the stage
  modport master (
    output in_valid, in_inst, in_imm_src, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_imm_src, in_tag, flush, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// ============================================================================
// imm_extract : combinational RISC-V immediate extraction and extension
// Revision: 1.0
// ============================================================================
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INST_W-1:0] in_inst,
  input  imm_src_e          imm_src,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);

  localparam bit IS_RV64 = (XLEN == XLEN_RV64);

  logic [31:0] raw;
  logic        sext;
  logic        unused_opcode;

  assign unused_opcode = ^in_inst[6:0];

  // raw holds the 32-bit result; sext says whether bit 31 fills the upper half on RV64
  always_comb begin
    raw     = '0;
    sext    = 1'b0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I: begin
        raw  = {{20{in_inst[31]}}, in_inst[31:20]};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        sext = 1'b1;
      end
      IMM_B: begin
        raw  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                in_inst[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_U: begin
        raw  = {in_inst[31:12], 12'b0};
        sext = 1'b1;
      end
      IMM_J: begin
        raw  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                in_inst[30:21], 1'b0};
        sext = 1'b1;
      end
      IMM_Z: begin
        raw = {27'b0, in_inst[19:15]};
      end
      IMM_SHAMT: begin
        if (IS_RV64) begin
          raw = {26'b0, in_inst[25:20]};
        end else begin
          raw     = {27'b0, in_inst[24:20]};
          illegal = in_inst[25];
        end
      end
      IMM_NONE: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  generate
    if (XLEN == XLEN_RV32) begin : g_rv32
      logic unused_sext;
      assign unused_sext = sext;
      assign imm         = raw;
    end else begin : g_rv64
      assign imm = {{(XLEN-32){sext & raw[31]}}, raw};
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// imm_gen_stage : registered immediate generator with 2-entry skid buffer
// Revision: 1.0
// ============================================================================
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  imm_gen_stage_if.slave  bus
);

  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .in_inst (bus.in_inst),
    .imm_src (imm_src_e'(bus.in_imm_src)),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             main_ill_q,   main_ill_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             skid_ill_q,   skid_ill_d;

  logic push;
  logic pop;

  // in_ready depends only on registered state, so no ready path crosses the stage
  assign bus.in_ready    = !skid_valid_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_imm     = main_imm_q;
  assign bus.out_tag     = main_tag_q;
  assign bus.out_illegal = main_ill_q;

  assign push = bus.in_valid && !skid_valid_q;
  assign pop  = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_tag_d   = main_tag_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_tag_d   = skid_tag_q;
    skid_ill_d   = skid_ill_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (pop) begin
      if (skid_valid_q) begin
        main_imm_d   = skid_imm_q;
        main_tag_d   = skid_tag_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_imm_d   = ext_imm;
        main_tag_d   = bus.in_tag;
        main_ill_d   = ext_illegal;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      // main is held (or empty); a held main sends the new entry to skid
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = ext_imm;
        skid_tag_d   = bus.in_tag;
        skid_ill_d   = ext_illegal;
      end else begin
        main_valid_d = 1'b1;
        main_imm_d   = ext_imm;
        main_tag_d   = bus.in_tag;
        main_ill_d   = ext_illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_tag_q   <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_tag_q   <= '0;
      skid_ill_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_tag_q   <= main_tag_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_tag_q   <= skid_tag_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// ============================================================================
// tb_imm_gen_stage : directed self-checking bench, XLEN=32 and XLEN=64 instances
// Revision: 1.0
// ============================================================================
module tb_imm_gen_stage;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] tag);
    b32.in_valid   = 1'b1;
    b32.in_inst    = inst;
    b32.in_imm_src = src;
    b32.in_tag     = tag;
    tick();
    b32.in_valid   = 1'b0;
  endtask

  task automatic push64(input logic [31:0] inst, input logic [2:0] src, input logic [31:0] tag);
    b64.in_valid   = 1'b1;
    b64.in_inst    = inst;
    b64.in_imm_src = src;
    b64.in_tag     = tag;
    tick();
    b64.in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32.in_valid = 1'b1;
    tick();
    tick();
    b32.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", b32.out_valid); end
    n_cmp++; if (b32.out_imm !== 32'h0) begin n_err++; $display("FAIL reset_imm: got %h want 0", b32.out_imm); end
    n_cmp++; if (b32.out_tag !== 32'h0) begin n_err++; $display("FAIL reset_tag: got %h want 0", b32.out_tag); end
    n_cmp++; if (b32.out_illegal !== 1'b0) begin n_err++; $display("FAIL reset_ill: got %b want 0", b32.out_illegal); end
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", b32.in_ready); end
    n_cmp++; if (b64.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid64: got %b want 0", b64.out_valid); end
  endtask

  task automatic test_itype();
    b32.out_ready = 1'b1;
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL itype_ready: got %b want 1", b32.in_ready); end
    push32(32'hFFF00093, 3'b000, 32'h0000_0100);
    n_cmp++; if (b32.out_valid !== 1'b1) begin n_err++; $display("FAIL itype_valid: got %b want 1", b32.out_valid); end
    n_cmp++; if (b32.out_imm !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL itype_imm: got %h want ffffffff", b32.out_imm); end
    n_cmp++; if (b32.out_illegal !== 1'b0) begin n_err++; $display("FAIL itype_ill: got %b want 0", b32.out_illegal); end
    n_cmp++; if (b32.out_tag !== 32'h100) begin n_err++; $display("FAIL itype_tag: got %h want 100", b32.out_tag); end
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL itype_drain: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] inst [4];
    logic [2:0]  src  [4];
    logic [31:0] exp  [4];
    inst[0] = 32'h00112623; src[0] = 3'b001; exp[0] = 32'h0000_000C;
    inst[1] = 32'hFE000EE3; src[1] = 3'b010; exp[1] = 32'hFFFF_FFFC;
    inst[2] = 32'h123452B7; src[2] = 3'b011; exp[2] = 32'h1234_5000;
    inst[3] = 32'h0010006F; src[3] = 3'b100; exp[3] = 32'h0000_0800;
    b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b32.in_valid   = 1'b1;
      b32.in_inst    = inst[i];
      b32.in_imm_src = src[i];
      b32.in_tag     = 32'h200 + i;
      tick();
      n_cmp++; if (b32.out_valid !== 1'b1 || b32.out_imm !== exp[i] || b32.out_tag !== 32'h200 + i)
        begin n_err++; $display("FAIL b2b_%0d: got v=%b imm=%h tag=%h want v=1 imm=%h tag=%h",
                                i, b32.out_valid, b32.out_imm, b32.out_tag, exp[i], 32'h200 + i); end
    end
    b32.in_valid = 1'b0;
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", b32.out_valid); end
  endtask

  task automatic test_backpressure();
    b32.out_ready  = 1'b0;
    b32.in_imm_src = 3'b000;
    b32.in_valid   = 1'b1;
    b32.in_inst    = 32'h00100013; b32.in_tag = 32'hA;
    tick();
    n_cmp++; if (b32.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", b32.in_ready); end
    b32.in_inst    = 32'h00200013; b32.in_tag = 32'hB;
    tick();
    n_cmp++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2: got %b want 0", b32.in_ready); end
    b32.in_inst    = 32'h00300013; b32.in_tag = 32'hC;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h1 || b32.out_tag !== 32'hA || b32.in_ready !== 1'b0)
        begin n_err++; $display("FAIL bp_stall_%0d: got v=%b imm=%h tag=%h rdy=%b want v=1 imm=1 tag=a rdy=0",
                                k, b32.out_valid, b32.out_imm, b32.out_tag, b32.in_ready); end
    end
    b32.out_ready = 1'b1;
    tick();
    n_cmp++; if (b32.out_imm !== 32'h2 || b32.out_tag !== 32'hB || b32.in_ready !== 1'b1)
      begin n_err++; $display("FAIL bp_pop1: got imm=%h tag=%h rdy=%b want imm=2 tag=b rdy=1", b32.out_imm, b32.out_tag, b32.in_ready); end
    tick();
    b32.in_valid = 1'b0;
    n_cmp++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h3 || b32.out_tag !== 32'hC)
      begin n_err++; $display("FAIL bp_pop2: got v=%b imm=%h tag=%h want v=1 imm=3 tag=c", b32.out_valid, b32.out_imm, b32.out_tag); end
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0 (duplicate)", b32.out_valid); end
  endtask

  task automatic test_shamt();
    b32.out_ready = 1'b1;
    push32(32'h02500013, 3'b110, 32'h300);
    n_cmp++; if (b32.out_imm !== 32'h5 || b32.out_illegal !== 1'b1)
      begin n_err++; $display("FAIL shamt32: got imm=%h ill=%b want imm=5 ill=1", b32.out_imm, b32.out_illegal); end
    push32(32'hFFFFFFFF, 3'b111, 32'h301);
    n_cmp++; if (b32.out_imm !== 32'h0 || b32.out_illegal !== 1'b1)
      begin n_err++; $display("FAIL none32: got imm=%h ill=%b want imm=0 ill=1", b32.out_imm, b32.out_illegal); end
    push32(32'h000F8073, 3'b101, 32'h302);
    n_cmp++; if (b32.out_imm !== 32'h1F || b32.out_illegal !== 1'b0)
      begin n_err++; $display("FAIL zimm32: got imm=%h ill=%b want imm=1f ill=0", b32.out_imm, b32.out_illegal); end
    tick();
  endtask

  task automatic test_xlen64();
    b64.out_ready = 1'b1;
    push64(32'hFFF00093, 3'b000, 32'h400);
    n_cmp++; if (b64.out_valid !== 1'b1 || b64.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || b64.out_illegal !== 1'b0)
      begin n_err++; $display("FAIL itype64: got v=%b imm=%h ill=%b want v=1 imm=ffffffffffffffff ill=0",
                              b64.out_valid, b64.out_imm, b64.out_illegal); end
    push64(32'h02500013, 3'b110, 32'h401);
    n_cmp++; if (b64.out_imm !== 64'h25 || b64.out_illegal !== 1'b0)
      begin n_err++; $display("FAIL shamt64: got imm=%h ill=%b want imm=25 ill=0", b64.out_imm, b64.out_illegal); end
    push64(32'h800002B7, 3'b011, 32'h402);
    n_cmp++; if (b64.out_imm !== 64'hFFFF_FFFF_8000_0000)
      begin n_err++; $display("FAIL utype64: got imm=%h want ffffffff80000000", b64.out_imm); end
    push64(32'h000F8073, 3'b101, 32'h403);
    n_cmp++; if (b64.out_imm !== 64'h1F)
      begin n_err++; $display("FAIL zimm64: got imm=%h want 1f", b64.out_imm); end
    tick();
  endtask

  task automatic test_flush();
    b32.out_ready  = 1'b0;
    b32.in_imm_src = 3'b000;
    b32.in_valid   = 1'b1;
    b32.in_inst    = 32'h00500013; b32.in_tag = 32'h500;
    tick();
    b32.in_inst    = 32'h00600013; b32.in_tag = 32'h501;
    tick();
    n_cmp++; if (b32.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_full: got rdy=%b want 0", b32.in_ready); end
    b32.in_inst = 32'h00700013; b32.in_tag = 32'h502;
    b32.flush   = 1'b1;
    tick();
    b32.flush    = 1'b0;
    b32.in_valid = 1'b0;
    n_cmp++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1)
      begin n_err++; $display("FAIL flush_clear: got v=%b rdy=%b want v=0 rdy=1", b32.out_valid, b32.in_ready); end
    b32.out_ready = 1'b1;
    tick();
    tick();
    n_cmp++; if (b32.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: got v=%b tag=%h want v=0", b32.out_valid, b32.out_tag); end
    push32(32'h00800013, 3'b000, 32'h503);
    n_cmp++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'h8 || b32.out_tag !== 32'h503)
      begin n_err++; $display("FAIL flush_after: got v=%b imm=%h tag=%h want v=1 imm=8 tag=503", b32.out_valid, b32.out_imm, b32.out_tag); end
    tick();
  endtask

  task automatic test_reset_mid();
    b32.out_ready  = 1'b0;
    b32.in_imm_src = 3'b001;
    b32.in_valid   = 1'b1;
    b32.in_inst    = 32'hFE000FA3; b32.in_tag = 32'h600;
    tick();
    b32.in_tag     = 32'h601;
    tick();
    b32.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (b32.out_valid !== 1'b0 || b32.out_imm !== 32'h0 || b32.out_tag !== 32'h0 ||
                 b32.out_illegal !== 1'b0 || b32.in_ready !== 1'b1)
      begin n_err++; $display("FAIL rst_mid: got v=%b imm=%h tag=%h ill=%b rdy=%b want 0 0 0 0 1",
                              b32.out_valid, b32.out_imm, b32.out_tag, b32.out_illegal, b32.in_ready); end
    b32.out_ready = 1'b1;
    push32(32'h00112623, 3'b001, 32'h602);
    n_cmp++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hC || b32.out_tag !== 32'h602)
      begin n_err++; $display("FAIL rst_push: got v=%b imm=%h tag=%h want v=1 imm=c tag=602", b32.out_valid, b32.out_imm, b32.out_tag); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_imm_src = '0; b32.in_tag = '0;
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_inst = '0; b64.in_imm_src = '0; b64.in_tag = '0;
    b64.flush = 1'b0; b64.out_ready = 1'b1;
    test_reset();
    test_itype();
    test_back_to_back();
    test_backpressure();
    test_shamt();
    test_xlen64();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
